// File: rtl/pe_cluster_sched.sv
// pe_cluster_sched: loads a weight then an activation stream into a PE cluster, starts it,
// and drains the captured column psums; load and compute waits are guarded by a watchdog.
module pe_cluster_sched #(
    parameter int DATA_WIDTH = 16,
    parameter int X_dim      = 3,
    parameter int W_COUNT    = 9,
    parameter int A_COUNT    = 25,
    parameter int TIMEOUT    = 1023
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cfg_start,
    output logic                        busy,
    input  logic [DATA_WIDTH-1:0]       in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [DATA_WIDTH-1:0]       filt_out,
    output logic [DATA_WIDTH-1:0]       act_out,
    output logic                        load_en_wght,
    output logic                        load_en_act,
    output logic                        start,
    input  logic                        cl_load_done,
    input  logic                        cl_compute_done,
    input  logic [X_dim*DATA_WIDTH-1:0] cl_pe_out,
    output logic [DATA_WIDTH-1:0]       res_data,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic                        res_last,
    output logic                        done,
    output logic                        error
);
    localparam int MAXC = W_COUNT > A_COUNT ? W_COUNT : A_COUNT;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int TW   = $clog2(TIMEOUT + 1);
    localparam int IW   = X_dim > 1 ? $clog2(X_dim) : 1;

    typedef enum logic [3:0] {IDLE, LOAD_W, LOAD_A, WAIT_LOAD, START, WAIT_COMP, DRAIN, DONE, ERR} state_t;

    state_t                state, nxt;
    logic [CW-1:0]         cnt;
    logic [TW-1:0]         wd;
    logic [IW-1:0]         idx;
    logic [DATA_WIDTH-1:0] bank [X_dim];
    logic                  err_q;
    logic                  beat, wd_exp, last_w, last_a, last_col;

    assign beat     = in_valid & in_ready;
    assign wd_exp   = wd == TW'(TIMEOUT - 1);
    assign last_w   = cnt == CW'(W_COUNT - 1);
    assign last_a   = cnt == CW'(A_COUNT - 1);
    assign last_col = idx == IW'(X_dim - 1);
    assign error    = err_q;

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= nxt;

    // a done level seen on the timeout cycle wins over the watchdog
    always_comb begin
        nxt = state;
        case (state)
            IDLE:      nxt = cfg_start ? LOAD_W : IDLE;
            LOAD_W:    nxt = beat && last_w ? LOAD_A : LOAD_W;
            LOAD_A:    nxt = beat && last_a ? WAIT_LOAD : LOAD_A;
            WAIT_LOAD: nxt = cl_load_done ? START : wd_exp ? ERR : WAIT_LOAD;
            START:     nxt = WAIT_COMP;
            WAIT_COMP: nxt = cl_compute_done ? DRAIN : wd_exp ? ERR : WAIT_COMP;
            DRAIN:     nxt = res_ready && last_col ? DONE : DRAIN;
            default:   nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = state != IDLE;
        in_ready  = state == LOAD_W || state == LOAD_A;
        start     = state == START;
        res_valid = state == DRAIN;
        res_data  = res_valid ? bank[idx] : '0;
        res_last  = res_valid && last_col;
        done      = state == DONE || state == ERR;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt          <= '0;
            wd           <= '0;
            idx          <= '0;
            err_q        <= 1'b0;
            filt_out     <= '0;
            act_out      <= '0;
            load_en_wght <= 1'b0;
            load_en_act  <= 1'b0;
            for (int i = 0; i < X_dim; i++) bank[i] <= '0;
        end else begin
            load_en_wght <= state == LOAD_W && beat;
            load_en_act  <= state == LOAD_A && beat;
            if (state == LOAD_W && beat) filt_out <= in_data;
            if (state == LOAD_A && beat) act_out <= in_data;
            cnt <= nxt != state ? '0 : cnt + CW'(beat);
            wd  <= nxt != state || !(state == WAIT_LOAD || state == WAIT_COMP) ? '0 : wd + 1'b1;
            idx <= state != DRAIN ? '0 : res_ready ? idx + 1'b1 : idx;
            if (state == IDLE && cfg_start) err_q <= 1'b0;
            else if (nxt == ERR)            err_q <= 1'b1;
            if (state == WAIT_COMP && cl_compute_done)
                for (int i = 0; i < X_dim; i++) bank[i] <= cl_pe_out[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end
endmodule

// File: tb/tb_pe_cluster_sched.sv
// tb_pe_cluster_sched: scoreboard bench for pe_cluster_sched covering nominal load, input gaps,
// result backpressure, watchdog timeout, done/timeout tie and mid-job reset.
module tb_pe_cluster_sched;
    localparam int DW = 16, XD = 3, WC = 9, AC = 25, TO = 8;

    logic          clk = 0, reset = 0, cfg_start = 0, in_valid = 0, res_ready = 0;
    logic          cl_load_done = 0, cl_compute_done = 0;
    logic [DW-1:0] in_data = '0;
    logic [XD*DW-1:0] cl_pe_out = '0;
    logic          busy, in_ready, load_en_wght, load_en_act, start, res_valid, res_last, done, error;
    logic [DW-1:0] filt_out, act_out, res_data;

    int errors = 0, checks = 0, n_w = 0, n_a = 0, n_start = 0, n_done = 0, mark = 0;
    logic [DW-1:0] wq[$], aq[$];
    logic [DW:0]   rq[$];

    pe_cluster_sched #(.DATA_WIDTH(DW), .X_dim(XD), .W_COUNT(WC), .A_COUNT(AC), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .cfg_start(cfg_start), .busy(busy),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .filt_out(filt_out), .act_out(act_out), .load_en_wght(load_en_wght), .load_en_act(load_en_act),
        .start(start), .cl_load_done(cl_load_done), .cl_compute_done(cl_compute_done), .cl_pe_out(cl_pe_out),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready), .res_last(res_last),
        .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fail(input string tag, input logic [31:0] obs);
        checks++;
        errors++;
        $error("FAIL %s: observed %0h where none was expected", tag, obs);
    endtask

    // scoreboard: every load pulse and result beat is matched against the queues
    always @(negedge clk) if (reset) begin
        if (load_en_wght) begin
            n_w++;
            if (wq.size() == 0) fail("wght_extra", filt_out);
            else chk("wght_data", filt_out, wq.pop_front());
        end
        if (load_en_act) begin
            n_a++;
            if (aq.size() == 0) fail("act_extra", act_out);
            else chk("act_data", act_out, aq.pop_front());
        end
        if (res_valid) begin
            if (rq.size() == 0) fail("res_extra", res_data);
            else begin
                chk("res_data", res_data, rq[0][DW-1:0]);
                chk("res_last", res_last, rq[0][DW]);
                if (res_ready) rq.delete(0);
            end
        end
        if (start) n_start++;
        if (done) n_done++;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "bench timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input bit gap);
        int t = 0;
        in_data  = d;
        in_valid = 1;
        @(negedge clk);
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) fail("in_ready_timeout", {16'h0, d});
        step();
        in_valid = 0;
        if (gap) begin
            in_data = ~d;
            step();
        end
    endtask

    task automatic load(input int wb, input int ab, input int na, input bit gap);
        n_w = 0;
        n_a = 0;
        cfg_start = 1;
        step();
        cfg_start = 0;
        chk("job_busy", busy, 1);
        chk("err_clr", error, 0);
        for (int i = 0; i < WC; i++) begin
            wq.push_back(DW'(wb + i));
            send(DW'(wb + i), gap);
        end
        for (int i = 0; i < na; i++) begin
            aq.push_back(DW'(ab + i));
            send(DW'(ab + i), gap);
        end
    endtask

    task automatic finish_job(input int lw, input int cw, input logic [XD*DW-1:0] pe, input int hold);
        repeat (lw) step();
        cl_load_done = 1;
        @(negedge clk);
        chk("start_pre", start, 0);
        @(negedge clk);
        chk("start", start, 1);
        step();
        cl_load_done = 0;
        chk("start_pulse", start, 0);
        repeat (cw - 1) step();
        cl_pe_out = pe;
        for (int i = 0; i < XD; i++) rq.push_back({i == XD - 1, pe[i*DW +: DW]});
        cl_compute_done = 1;
        step();
        cl_compute_done = 0;
        cl_pe_out = ~pe;
        for (int b = 0; b < XD; b++) begin
            res_ready = 0;
            repeat (hold) step();
            res_ready = 1;
            @(negedge clk);
            chk("res_valid", res_valid, 1);
            step();
        end
        res_ready = 0;
        @(negedge clk);
        chk("done", done, 1);
        chk("err_ok", error, 0);
        step();
        chk("idle_busy", busy, 0);
        chk("done_pulse", done, 0);
        chk("rq_empty", rq.size(), 0);
        chk("n_w", n_w, WC);
        chk("n_a", n_a, AC);
    endtask

    initial begin
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_outs", {filt_out, act_out, res_data, load_en_wght, load_en_act, start, res_valid, res_last, done, error, in_ready}, '0);
        step();
        reset = 1;
        step();

        // nominal job
        load(1, 101, AC, 0);
        finish_job(3, 2, {16'd9, 16'd8, 16'd7}, 0);

        // in_valid toggling every cycle
        load(1, 101, AC, 1);
        finish_job(3, 2, {16'h0c03, 16'h0b02, 16'h0a01}, 0);

        // result backpressure, 5 idle cycles per beat
        load(16'h10, 16'h20, AC, 0);
        finish_job(1, 3, {16'hbeef, 16'h1234, 16'hfff0}, 5);

        // watchdog expiry in WAIT_LOAD
        mark = n_start;
        load(16'h200, 16'h300, AC, 0);
        repeat (TO - 1) step();
        @(negedge clk);
        chk("wd_pre_done", done, 0);
        chk("wd_pre_err", error, 0);
        step();
        chk("wd_done", done, 1);
        chk("wd_err", error, 1);
        step();
        chk("wd_idle", busy, 0);
        chk("wd_sticky", error, 1);
        chk("wd_no_start", n_start, mark);
        chk("wd_n_a", n_a, AC);

        // compute_done on the exact timeout cycle
        load(16'h40, 16'h50, AC, 0);
        finish_job(0, TO, {16'h0333, 16'h0222, 16'h0111}, 0);

        // asynchronous reset in the middle of LOAD_A
        load(16'h400, 16'h500, 12, 0);
        mark = n_done;
        #2 reset = 0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_filt", filt_out, 0);
        chk("mid_rst_act", act_out, 0);
        chk("mid_rst_ctl", {load_en_wght, load_en_act, in_ready, start, res_valid, res_last, done, error}, 0);
        wq.delete();
        aq.delete();
        repeat (3) step();
        reset = 1;
        step();
        chk("rst_no_done", n_done, mark);
        chk("rst_idle", busy, 0);
        load(16'h600, 16'h700, AC, 0);
        finish_job(2, 4, {16'h7777, 16'h6666, 16'h5555}, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
